// File: rtl/imm_chunker_if.sv
// Handshake bundle for imm_chunker: constant in, 3-bit chunks out.
interface imm_chunker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_value;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_imm;
  logic       out_first;
  logic       out_last;
  logic [1:0] out_nchunks;

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_imm,
    output out_first, out_last, out_nchunks
  );

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_imm,
    input  out_first, out_last, out_nchunks
  );
endinterface

// File: rtl/imm_chunker.sv
// Splits an 8-bit constant into the shortest run of 3-bit immediates
// that the sign-extend / shift-or consumer rebuilds, MSB chunk first.
module imm_chunker #(
  parameter bit FORCE_FULL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  imm_chunker_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e     state_q, state_d;
  logic [7:0] v_q, v_d;
  logic [1:0] n_q, n_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] n_in;
  logic [1:0] pos;
  logic       last;

  // Chunks needed so that sign extension of the head restores the top bits
  always_comb begin
    if (FORCE_FULL)
      n_in = 2'd3;
    else if (&bus.in_value[7:2] || ~|bus.in_value[7:2])
      n_in = 2'd1;
    else if (&bus.in_value[7:5] || ~|bus.in_value[7:5])
      n_in = 2'd2;
    else
      n_in = 2'd3;
  end

  assign pos  = n_q - 2'd1 - idx_q;
  assign last = (idx_q == n_q - 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      v_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    v_d     = v_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          v_d     = bus.in_value;
          n_d     = n_in;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_imm     = '0;
    bus.out_first   = 1'b0;
    bus.out_last    = 1'b0;
    bus.out_nchunks = '0;
    unique case (state_q)
      IDLE: bus.in_ready = 1'b1;
      EMIT: begin
        bus.out_valid   = 1'b1;
        bus.out_first   = (idx_q == 2'd0);
        bus.out_last    = last;
        bus.out_nchunks = n_q;
        unique case (pos)
          2'd0:    bus.out_imm = v_q[2:0];
          2'd1:    bus.out_imm = v_q[5:3];
          default: bus.out_imm = {v_q[7], v_q[7], v_q[6]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imm_chunker.sv
// Directed and swept checks of imm_chunker in both chunking modes,
// with a queue of expected chunks filled on accept and drained on transfer.
module tb_imm_chunker;

  typedef struct {
    logic [2:0] imm;
    logic       first;
    logic       last;
    logic [1:0] n;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [7:0] in_value;
  logic out_ready;
  bit   sel;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  exp_t sb[$];
  logic [7:0] recon;

  logic       ov, ir, ofirst, olast;
  logic [2:0] oimm;
  logic [1:0] onch;

  imm_chunker_if b0();
  imm_chunker_if b1();

  imm_chunker #(.FORCE_FULL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  imm_chunker #(.FORCE_FULL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  assign b0.in_valid  = in_valid & ~sel;
  assign b1.in_valid  = in_valid & sel;
  assign b0.in_value  = in_value;
  assign b1.in_value  = in_value;
  assign b0.out_ready = out_ready & ~sel;
  assign b1.out_ready = out_ready & sel;

  always_comb begin
    ov     = sel ? b1.out_valid   : b0.out_valid;
    ir     = sel ? b1.in_ready    : b0.in_ready;
    oimm   = sel ? b1.out_imm     : b0.out_imm;
    ofirst = sel ? b1.out_first   : b0.out_first;
    olast  = sel ? b1.out_last    : b0.out_last;
    onch   = sel ? b1.out_nchunks : b0.out_nchunks;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] val);
    int sv;
    int n;
    exp_t e;
    sv = int'($signed(val));
    if (sv >= -4 && sv <= 3)        n = 1;
    else if (sv >= -32 && sv <= 31) n = 2;
    else                            n = 3;
    if (sel) n = 3;
    for (int k = 0; k < n; k++) begin
      e.imm   = 3'((sv >>> (3 * (n - 1 - k))) & 7);
      e.first = (k == 0);
      e.last  = (k == n - 1);
      e.n     = 2'(n);
      e.val   = val;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] val);
    int budget = 20;
    while (ir !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) chk("accept_timeout", 0, 1);
    in_valid = 1'b1;
    in_value = val;
    push_exp(val);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("chunk0_latency", ov, 1);
    chk("busy_in_ready", ir, 0);
  endtask

  // Compare the chunk about to transfer against the queue head
  task automatic take();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_chunk", ov, 0);
      return;
    end
    e = sb.pop_front();
    xfers++;
    chk("out_valid", ov, 1);
    chk("out_imm", oimm, e.imm);
    chk("out_first", ofirst, e.first);
    chk("out_last", olast, e.last);
    chk("out_nchunks", onch, e.n);
    if (e.first) recon = {{5{oimm[2]}}, oimm};
    else         recon = {recon[4:0], oimm};
    if (e.last) chk("reconstruct", recon, e.val);
  endtask

  task automatic drain(input int pct, input int stall);
    int budget = 400;
    while (sb.size() > 0 && budget > 0) begin
      if (ov === 1'b1) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          budget--;
          chk("stall_imm", oimm, sb[0].imm);
          chk("stall_first", ofirst, sb[0].first);
          chk("stall_last", olast, sb[0].last);
          chk("stall_in_ready", ir, 0);
        end
        out_ready = ($urandom_range(99) >= pct);
        if (out_ready) take();
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      budget--;
    end
    out_ready = 1'b0;
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    chk("done_out_valid", ov, 0);
    chk("done_in_ready", ir, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_value  = 8'h55;
    out_ready = 1'b0;
    sel       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    for (int m = 0; m < 2; m++) begin
      sel = bit'(m);
      #0;
      chk("rst_out_valid", ov, 0);
      chk("rst_in_ready", ir, 1);
      chk("rst_out_imm", oimm, 0);
      chk("rst_nchunks", onch, 0);
      chk("rst_first_last", {ofirst, olast}, 0);
    end
    sel = 1'b0;

    send(8'h03); drain(0, 0);
    send(8'hFD); drain(0, 0);
    send(8'h1C); drain(0, 0);
    send(8'h80); drain(0, 0);
    send(8'h7F); drain(0, 0);

    xfers = 0;
    send(8'h7F); drain(0, 4);
    chk("stall_xfers", xfers, 3);

    send(8'h80);
    out_ready = 1'b1;
    take();
    @(posedge clk); #1;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("abort_out_valid", ov, 0);
    chk("abort_in_ready", ir, 1);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_quiet", ov, 0);
    end
    out_ready = 1'b0;
    send(8'h03); drain(0, 0);

    sel = 1'b1;
    #0;
    send(8'h03); drain(0, 0);

    for (int m = 0; m < 2; m++) begin
      sel = bit'(m);
      #0;
      for (int v = 0; v < 256; v++) begin
        send(8'(v));
        drain(40, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
